alu_issue: RTL

- Issue/writeback stage wrapped around the 4-bit ALU.
- Holds a small register file and accepts register-to-register instructions over a valid/ready handshake.
- Drives the ALU operand and select inputs, captures its result and flags, and writes back.
- Presents each completed result on a valid/ready output channel.
- The ALU is instantiated outside this block: `alu_*` outputs feed it, `alu_*` inputs return from it combinationally.

---
 rtl/alu_issue.sv | 106 ++++++++++
 1 files changed

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - issue/writeback stage driving an external combinational ALU
module alu_issue #(
    parameter int WIDTH = 4,
    parameter int NREG  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2:0]                in_op,
    input  logic [$clog2(NREG)-1:0]   in_rd,
    input  logic [$clog2(NREG)-1:0]   in_rs1,
    input  logic [$clog2(NREG)-1:0]   in_rs2,
    input  logic                      ld_en,
    input  logic [$clog2(NREG)-1:0]   ld_addr,
    input  logic [WIDTH-1:0]          ld_data,
    output logic [WIDTH-1:0]          alu_a,
    output logic [WIDTH-1:0]          alu_b,
    output logic [2:0]                alu_sel,
    input  logic [WIDTH-1:0]          alu_result,
    input  logic                      alu_overflow,
    input  logic                      alu_carry,
    input  logic                      alu_zero,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [$clog2(NREG)-1:0]   out_rd,
    output logic [2:0]                out_flags
);

    localparam int AW = $clog2(NREG);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state;
    logic [WIDTH-1:0] regs [NREG];
    logic [2:0]       op_q;
    logic [AW-1:0]    rd_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] data_q;
    logic [AW-1:0]    out_rd_q;
    logic [2:0]       flags_q;

    // Handshake outputs are pure decodes of the state register
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == RESP);

    // Operands are captured at accept so they hold their last value outside EXEC
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_sel   = op_q;
    assign out_data  = data_q;
    assign out_rd    = out_rd_q;
    assign out_flags = flags_q;

    // Issue FSM, register file and writeback
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= 3'b000;
            rd_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            data_q   <= '0;
            out_rd_q <= '0;
            flags_q  <= 3'b000;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (ld_en) begin
                        regs[ld_addr] <= ld_data;
                    end
                    if (in_valid) begin
                        // A load landing in the same cycle is forwarded into the operands
                        a_q   <= (ld_en && ld_addr == in_rs1) ? ld_data : regs[in_rs1];
                        b_q   <= (ld_en && ld_addr == in_rs2) ? ld_data : regs[in_rs2];
                        op_q  <= in_op;
                        rd_q  <= in_rd;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    regs[rd_q] <= alu_result;
                    data_q     <= alu_result;
                    out_rd_q   <= rd_q;
                    // Only add and subtract produce meaningful flags
                    if (op_q[2:1] == 2'b00) begin
                        flags_q <= {alu_overflow, alu_carry, alu_zero};
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
